freelist_nway: RTL and testbench
================================

Name: freelist_nway

Overview:
- Parametrised N-way physical-register free list. Successor to the fixed 3-way/32-entry freelist.
- Sits between dispatch (allocation of Tnew), retire (return of Told) and branch recovery (head restore from a checkpoint).
- Adds generic way count and depth, compacted allocation and return, explicit occupancy, and wrap-bit pointers for exact full/empty.

Parameters:
- WAYS, 3, dispatch/retire ways per cycle (1..8).
- DEPTH, 32, entries; power of two, >= WAYS.
- PR_W, 6, physical register tag width.
- ARCH_REGS, 32, first free PR at reset.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- dispatch_en  in  WAYS  per-way allocation request; any bit pattern legal.
- free_reg  out  WAYS*PR_W  allocated tag per way.
- free_valid  out  WAYS  way's request granted.
- dispatch_stall  out  1  popcount(dispatch_en) > count.
- retire_en  in  WAYS  per-way return of a Told.
- retire_reg  in  WAYS*PR_W  returned tags.
- recover_en  in  1  branch mispredict recovery.
- recover_head  in  log2(DEPTH)+1  checkpointed head pointer, including wrap bit.
- head_ptr  out  log2(DEPTH)+1  current head; this is the checkpoint source.
- count  out  log2(DEPTH)+1  free entries, 0..DEPTH.
- fl_error  out  1  sticky error flag; exists only under the optional feature.

Behaviour:
- Storage and pointers:
  - array[DEPTH] of PR_W bits.
  - head and tail are log2(DEPTH)+1 bits. The MSB is the wrap bit; the index is the low bits.
  - count = tail - head, modulo 2*DEPTH.
- Async reset:
  - array[i] = ARCH_REGS + i; head = 0; tail = DEPTH (wrap bit set); count = DEPTH.
  - free_valid = 0; fl_error = 0.
  - Reset asserted mid-operation discards all in-flight state.
- Allocation (combinational from registered state):
  - Define rank(i) = popcount(dispatch_en[i-1:0]).
  - free_reg[i] = array[(head + rank(i)) mod DEPTH].
  - free_valid[i] = dispatch_en[i] && rank(i) < count && !recover_en.
  - Disabled ways: free_reg is don't-care and free_valid = 0.
- Stall and all-or-nothing grant:
  - dispatch_stall = (popcount(dispatch_en) > count) && !recover_en.
  - On stall, no way is granted: free_valid forced to all 0 and head unchanged.
- Head update at the clock edge:
  - head += popcount(free_valid), modulo 2*DEPTH.
  - Grants are consumed with zero-cycle latency: the tag is usable in the same cycle it is granted.
- Return:
  - Enabled retire ways are compacted in ascending way order.
  - array[(tail + rank_r(i)) mod DEPTH] <= retire_reg[i].
  - tail += popcount(retire_en).
  - There is no same-cycle bypass: a returned tag becomes allocatable the next cycle.
- Simultaneous dispatch and retire in one cycle:
  - Both apply.
  - The stall decision uses the pre-edge count only.
- Recovery (recover_en = 1):
  - head <= recover_head.
  - All dispatch that cycle is ignored.
  - A retire in the same cycle still pushes and advances tail.
  - Recovery is accepted while count = 0.
- Wrap-around:
  - All index arithmetic is modulo DEPTH.
  - Wrap bits distinguish full (count = DEPTH) from empty (count = 0).
- Overflow: a retire that would push count above DEPTH is illegal and is dropped entirely; tail does not move.

Optional Feature:
- Macro: FREELIST_ERR_EN.
- Defined:
  - fl_error is set on an overflow attempt, a recover_head with tail - recover_head > DEPTH, or a duplicate tag within one cycle's retire_reg among enabled ways.
  - fl_error stays set until reset.
- Undefined: the fl_error port is tied to 0 and no checking logic is built.

Test Plan:
- Reset release:
  - count = 32; head_ptr = 0.
  - dispatch_en = 3'b111 gives free_reg = {34, 33, 32} (way 2..0), free_valid = 111.
  - Next cycle head_ptr = 3, count = 29.
- Compaction:
  - From reset, dispatch_en = 3'b101 gives way 0 = 32 and way 2 = 33; free_valid = 101.
  - In the same cycle, retire_en = 3'b110 with tags 5 and 9 lands 5 at index 0 and 9 at index 1. The writes wrap because tail index = 0.
- Drain and stall:
  - Allocate 10 cycles x 3 ways; count = 2.
  - dispatch_en = 111 then gives dispatch_stall = 1, free_valid = 000, and head unchanged.
  - dispatch_en = 011 is granted 62 and 63.
- Recovery:
  - Checkpoint head_ptr = 3, then allocate 6 more entries.
  - recover_en with recover_head = 3, plus retire_en = 001 with tag 7.
  - Result: head_ptr = 3; count restored plus 1; free_valid = 0 during the recovery cycle.
- Full boundary:
  - At count = 32, retire_en = 001 is dropped and tail is unchanged.
  - With FREELIST_ERR_EN defined, fl_error = 1 from the next cycle.
- Async reset mid-stream:
  - Assert reset between clock edges after traffic.
  - count = 32 and free_valid = 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/freelist_nway.sv
// N-way physical-register free list with wrap-bit head/tail pointers and compacted allocate/return.
// Optional sticky error checking is built only when FREELIST_ERR_EN is defined.
module freelist_nway #(
   parameter int WAYS      = 3,
   parameter int DEPTH     = 32,
   parameter int PR_W      = 6,
   parameter int ARCH_REGS = 32
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [WAYS-1:0]            dispatch_en,
   output logic [WAYS*PR_W-1:0]       free_reg,
   output logic [WAYS-1:0]            free_valid,
   output logic                       dispatch_stall,
   input  logic [WAYS-1:0]            retire_en,
   input  logic [WAYS*PR_W-1:0]       retire_reg,
   input  logic                       recover_en,
   input  logic [$clog2(DEPTH):0]     recover_head,
   output logic [$clog2(DEPTH):0]     head_ptr,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       fl_error
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW:0] DEPTH_X = (PW+1)'(DEPTH);

   logic [PR_W-1:0] mem [DEPTH];
   logic [PW-1:0]   head, tail;
   logic [PW-1:0]   d_rank [WAYS];
   logic [PW-1:0]   r_rank [WAYS];
   logic [AW-1:0]   r_idx  [WAYS];
   logic [PW-1:0]   d_pop, r_pop, g_pop;
   logic            stall_c, overflow;

   assign count    = tail - head;
   assign head_ptr = head;

   // Ranks give each enabled way its slot offset from head (dispatch) or tail (retire).
   always_comb begin
      d_pop = '0;
      r_pop = '0;
      for (int i = 0; i < WAYS; i++) begin
         d_rank[i] = d_pop;
         r_rank[i] = r_pop;
         r_idx[i]  = tail[AW-1:0] + r_pop[AW-1:0];
         d_pop     = d_pop + PW'(dispatch_en[i]);
         r_pop     = r_pop + PW'(retire_en[i]);
      end
   end

   assign stall_c        = (d_pop > count) && !recover_en;
   assign dispatch_stall = stall_c;
   assign g_pop          = (stall_c || recover_en) ? '0 : d_pop;

   // Allocated entries leave the list this cycle, so their slots may take returned tags.
   assign overflow = ({1'b0, count} + {1'b0, r_pop}) > (DEPTH_X + {1'b0, g_pop});

   always_comb begin
      logic [AW-1:0] idx;
      idx        = '0;
      free_reg   = '0;
      free_valid = '0;
      for (int i = 0; i < WAYS; i++) begin
         idx = head[AW-1:0] + d_rank[i][AW-1:0];
         free_reg[i*PR_W +: PR_W] = mem[idx];
         free_valid[i] = dispatch_en[i] && (d_rank[i] < count) && !stall_c
                         && !recover_en && !reset;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head <= '0;
         tail <= PW'(DEPTH);
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= PR_W'(ARCH_REGS + i);
         end
      end else begin
         head <= recover_en ? recover_head : head + g_pop;
         if (!overflow) begin
            tail <= tail + r_pop;
            for (int i = 0; i < WAYS; i++) begin
               if (retire_en[i]) begin
                  mem[r_idx[i]] <= retire_reg[i*PR_W +: PR_W];
               end
            end
         end
      end
   end

`ifdef FREELIST_ERR_EN
   logic          err_q, dup;
   logic [PW-1:0] rec_span;

   assign rec_span = tail - recover_head;

   always_comb begin
      dup = 1'b0;
      for (int i = 0; i < WAYS; i++) begin
         for (int j = 0; j < i; j++) begin
            if (retire_en[i] && retire_en[j] &&
                retire_reg[i*PR_W +: PR_W] == retire_reg[j*PR_W +: PR_W]) begin
               dup = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (overflow || dup || (recover_en && rec_span > PW'(DEPTH))) begin
         err_q <= 1'b1;
      end
   end

   assign fl_error = err_q;
`else
   assign fl_error = 1'b0;
`endif

endmodule

// File: tb/tb_freelist_nway.sv
// Self-checking bench for freelist_nway: array/pointer reference model feeding an expected queue,
// drained by an independent monitor; directed boundary cases followed by random traffic.
module tb_freelist_nway;

   localparam int WAYS      = 3;
   localparam int DEPTH     = 32;
   localparam int PR_W      = 6;
   localparam int ARCH_REGS = 32;
   localparam int PW        = 6;
   localparam int EW        = 2 + WAYS + WAYS*PR_W + 2*PW;

   logic                  clock = 1'b0;
   logic                  reset;
   logic [WAYS-1:0]       dispatch_en  = '0;
   logic [WAYS-1:0]       retire_en    = '0;
   logic [WAYS*PR_W-1:0]  retire_reg   = '0;
   logic                  recover_en   = 1'b0;
   logic [PW-1:0]         recover_head = '0;
   logic [WAYS*PR_W-1:0]  free_reg;
   logic [WAYS-1:0]       free_valid;
   logic                  dispatch_stall;
   logic [PW-1:0]         head_ptr, count;
   logic                  fl_error;

   freelist_nway #(.WAYS(WAYS), .DEPTH(DEPTH), .PR_W(PR_W), .ARCH_REGS(ARCH_REGS)) dut (
      .clock(clock), .reset(reset), .dispatch_en(dispatch_en), .free_reg(free_reg),
      .free_valid(free_valid), .dispatch_stall(dispatch_stall), .retire_en(retire_en),
      .retire_reg(retire_reg), .recover_en(recover_en), .recover_head(recover_head),
      .head_ptr(head_ptr), .count(count), .fl_error(fl_error)
   );

   always #5 clock = ~clock;

   int vectors = 0;
   int miscompares = 0;
   logic [EW-1:0] exp_q [$];

   int m_arr [DEPTH];
   int m_h, m_t;
   bit m_err;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < DEPTH; i++) m_arr[i] = ARCH_REGS + i;
      m_h = 0;
      m_t = DEPTH;
      m_err = 0;
   endfunction

   function automatic int model_count();
      return (m_t - m_h) & (2*DEPTH - 1);
   endfunction

   // Drive one cycle of stimulus, queue the expected outputs, then advance the model past the edge.
   task automatic step(input logic [2:0] den, input logic [2:0] ren, input logic [17:0] regs,
                       input logic rec, input logic [5:0] rh);
      int cnt, pe, pr, rank, g;
      logic stall, ov, dup;
      logic [2:0] valid;
      logic [17:0] eregs;
      @(negedge clock);
      dispatch_en = den; retire_en = ren; retire_reg = regs;
      recover_en = rec; recover_head = rh;
      cnt = model_count();
      pe = $countones(den);
      pr = $countones(ren);
      stall = (pe > cnt) && !rec;
      rank = 0; valid = '0; eregs = '0;
      for (int i = 0; i < WAYS; i++) begin
         if (den[i]) begin
            eregs[i*PR_W +: PR_W] = 6'(m_arr[(m_h + rank) % DEPTH]);
            valid[i] = !stall && !rec;
            rank++;
         end
      end
      dup = 0;
      for (int i = 0; i < WAYS; i++)
         for (int j = i + 1; j < WAYS; j++)
            if (ren[i] && ren[j] && regs[i*PR_W +: PR_W] == regs[j*PR_W +: PR_W]) dup = 1;
      g = (stall || rec) ? 0 : pe;
      ov = (cnt + pr) > (DEPTH + g);
      exp_q.push_back({stall, valid, eregs, 6'(m_h), 6'(cnt), m_err});
`ifdef FREELIST_ERR_EN
      if (ov || dup || (rec && ((m_t - int'(rh)) & (2*DEPTH - 1)) > DEPTH)) m_err = 1;
`endif
      m_h = rec ? int'(rh) : ((m_h + g) & (2*DEPTH - 1));
      if (!ov) begin
         rank = 0;
         for (int i = 0; i < WAYS; i++) begin
            if (ren[i]) begin
               m_arr[(m_t + rank) % DEPTH] = int'(regs[i*PR_W +: PR_W]);
               rank++;
            end
         end
         m_t = (m_t + pr) & (2*DEPTH - 1);
      end
   endtask

   // Assert reset between edges and check that state clears without any clock edge.
   task automatic do_reset();
      @(posedge clock);
      #2;
      reset = 1'b1;
      dispatch_en = 3'b111; retire_en = '0; recover_en = 1'b0;
      #1;
      check("rst_count", 64'(count), 64'd32);
      check("rst_head", 64'(head_ptr), 64'd0);
      check("rst_valid", 64'(free_valid), 64'd0);
      check("rst_err", 64'(fl_error), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      dispatch_en = '0;
      model_reset();
   endtask

   initial begin : monitor
      logic [EW-1:0] e, a;
      logic [17:0] mask;
      forever begin
         @(negedge clock);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            mask = {{6{dispatch_en[2]}}, {6{dispatch_en[1]}}, {6{dispatch_en[0]}}};
            a = {dispatch_stall, free_valid, free_reg & mask, head_ptr, count, fl_error};
            check("cycle", 64'(a), 64'(e));
         end
      end
   end

   initial begin : stimulus
      int cnt, lim, k;
      logic [2:0] den, ren;
      logic rec;
      model_reset();
      reset = 1'b1;
      dispatch_en = 3'b111;
      #2;
      check("init_count", 64'(count), 64'd32);
      check("init_head", 64'(head_ptr), 64'd0);
      check("init_valid", 64'(free_valid), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      dispatch_en = '0;

      // First allocation after reset
      step(3'b111, 3'b000, '0, 1'b0, '0);
      #1;
      check("first_regs", 64'(free_reg), 64'({6'd34, 6'd33, 6'd32}));
      check("first_valid", 64'(free_valid), 64'b111);
      @(posedge clock); #1;
      check("first_head", 64'(head_ptr), 64'd3);
      check("first_count", 64'(count), 64'd29);

      // Compaction with simultaneous wrapping retire at full occupancy
      do_reset();
      step(3'b101, 3'b110, {6'd9, 6'd5, 6'd0}, 1'b0, '0);
      #1;
      check("cmp_valid", 64'(free_valid), 64'b101);
      check("cmp_way0", 64'(free_reg[5:0]), 64'd32);
      check("cmp_way2", 64'(free_reg[17:12]), 64'd33);
      @(posedge clock); #1;
      check("cmp_count", 64'(count), 64'd32);
      for (int i = 0; i < 10; i++) step(3'b111, 3'b000, '0, 1'b0, '0);
      step(3'b011, 3'b000, '0, 1'b0, '0);
      #1;
      check("cmp_wrap_tags", 64'(free_reg[11:0]), 64'({6'd9, 6'd5}));

      // Drain and stall
      do_reset();
      for (int i = 0; i < 10; i++) step(3'b111, 3'b000, '0, 1'b0, '0);
      step(3'b111, 3'b000, '0, 1'b0, '0);
      #1;
      check("drain_stall", 64'(dispatch_stall), 64'd1);
      check("drain_valid", 64'(free_valid), 64'd0);
      @(posedge clock); #1;
      check("drain_head", 64'(head_ptr), 64'd30);
      step(3'b011, 3'b000, '0, 1'b0, '0);
      #1;
      check("drain_tags", 64'(free_reg[11:0]), 64'({6'd63, 6'd62}));
      step(3'b000, 3'b000, '0, 1'b1, 6'd28);

      // Recovery with a same-cycle retire
      do_reset();
      step(3'b111, 3'b000, '0, 1'b0, '0);
      step(3'b111, 3'b000, '0, 1'b0, '0);
      step(3'b111, 3'b000, '0, 1'b0, '0);
      step(3'b111, 3'b001, 18'd7, 1'b1, 6'd3);
      #1;
      check("rec_valid", 64'(free_valid), 64'd0);
      @(posedge clock); #1;
      check("rec_head", 64'(head_ptr), 64'd3);
      check("rec_count", 64'(count), 64'd30);

      // Full boundary: overflow retire is dropped
      do_reset();
      step(3'b000, 3'b001, 18'd7, 1'b0, '0);
      @(posedge clock); #1;
      check("full_count", 64'(count), 64'd32);
`ifdef FREELIST_ERR_EN
      check("full_err", 64'(fl_error), 64'd1);
`endif

      // Random traffic with legal checkpoints and one mid-stream reset
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if (i == 200) do_reset();
         cnt = model_count();
         den = 3'($urandom_range(0, 7));
         ren = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
         rec = ($urandom_range(0, 9) == 0);
         lim = DEPTH - cnt - WAYS;
         k = (lim > 0) ? $urandom_range(0, lim) : 0;
         step(den, ren, 18'($urandom), rec, 6'((m_h - k) & (2*DEPTH - 1)));
      end

      @(negedge clock);
      #4;
      if (exp_q.size() != 0) check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
